cache_access_sequencer: RTL and testbench
=========================================

// Module: cache_access_sequencer
// PURPOSE
//  Multi-cycle FSM sequencing one CPU access at a time through the direct-mapped cache datapath.
//  Sits between the CPU request port, the cache tag/data arrays and main memory.
//  Reads: serviced from cache on hit; line filled from memory on miss.
//  Writes: write-allocate, write-through, one-word blocks.
//  Replaces the purely combinational read/write steering with registered, handshaked sequencing.
// PARAMETERS
//  ADDR_W  32  CPU/memory byte address width
//  DATA_W  32  word width
//  CNT_W   32  width of the perf counters (CACHE_PERF_CNT_EN only)
// PORTS
//  clk             in   1       single clock, rising edge
//  rst_n           in   1       asynchronous active-low reset
//  cpu_req_valid   in   1       CPU request present
//  cpu_req_we      in   1       1 = write, 0 = read
//  cpu_req_addr    in   ADDR_W  request address
//  cpu_req_wdata   in   DATA_W  write data
//  cpu_req_ready   out  1       request accepted when valid & ready
//  cpu_resp_valid  out  1       one-cycle completion pulse
//  cpu_resp_rdata  out  DATA_W  read data, valid with resp_valid on reads
//  hit             in   1       tag compare for cache_addr (combinational from tag array)
//  cache_rdata     in   DATA_W  data array read word
//  cache_read      out  1       data array read strobe
//  cache_write     out  1       data array write strobe
//  tag_write       out  1       write tag and set valid for cache_addr
//  cache_addr      out  ADDR_W  latched request address
//  cache_wdata     out  DATA_W  word to data array
//  mem_req         out  1       memory request, held until mem_ack
//  mem_we          out  1       memory write (write-through)
//  mem_addr        out  ADDR_W  memory address (= latched address)
//  mem_wdata       out  DATA_W  memory write data
//  mem_ack         in   1       memory done; mem_rdata valid this cycle on reads
//  mem_rdata       in   DATA_W  memory read word
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except cpu_req_ready=1; address/data registers 0.
//  States: IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, RESP.
//  IDLE: ready=1. On valid, latch addr/we/wdata -> LOOKUP. Otherwise stay.
//  LOOKUP: ready=0, cache_addr=latched addr.
//   - Read hit: cache_read=1; capture cache_rdata -> RESP.
//   - Read miss: -> MEM_RD.
//   - Write, hit or miss: cache_write=1, tag_write=1, cache_wdata=wdata -> MEM_WR.
//  MEM_RD: mem_req=1, mem_we=0. Wait for mem_ack; on ack capture mem_rdata -> FILL.
//  FILL: cache_write=1, tag_write=1, cache_wdata=captured mem word -> RESP.
//  MEM_WR: mem_req=1, mem_we=1, mem_wdata=wdata; on mem_ack -> RESP.
//  RESP: resp_valid=1 for exactly 1 cycle; rdata=captured word (0 on writes) -> IDLE.
//   - cpu_req_ready is 0 here; next request is accepted in IDLE.
//  Latency, accept to resp_valid:
//   - read hit: 2 cycles
//   - read miss: 3 + N cycles
//   - write: 2 + N cycles
//   - N = cycles mem_req is high before mem_ack (N >= 1; ack in first req cycle allowed)
//  Memory handshake:
//   - mem_req/mem_we/mem_addr/mem_wdata are stable from assertion until the ack cycle.
//   - mem_req drops the cycle after ack.
//   - mem_ack outside MEM_RD/MEM_WR is ignored.
//  Only one outstanding access; cpu_req_valid outside IDLE is ignored (no queuing).
//  cache_read/cache_write/tag_write are never high together with each other's conflicting use.
//  Strobes are registered-state decodes only; no strobe in IDLE or RESP.
//  Reset mid-operation: immediate return to IDLE; mem_req deasserts asynchronously.
//   - A partially completed fill/write is abandoned; tag array content is unspecified for that index.
// CONFIGURATION
//  CACHE_PERF_CNT_EN defined: adds outputs hit_count, miss_count [CNT_W-1:0].
//   - Count LOOKUP-cycle hits and misses (reads and writes).
//   - Saturate at all-ones; reset to 0.
//  Not defined: ports and counters absent; FSM behaviour identical.
// TESTING
//  1. Reset, read 0x100 (miss, mem_ack after 3 cycles, mem_rdata=0xDEADBEEF):
//     -> mem_req 3 cycles, FILL writes 0xDEADBEEF, resp_rdata=0xDEADBEEF 6 cycles after accept.
//  2. Repeat read 0x100 with hit=1, cache_rdata=0xDEADBEEF:
//     -> no mem_req, resp_valid 2 cycles after accept, rdata=0xDEADBEEF.
//  3. Write 0x200 data 0x12345678, ack after 1 cycle:
//     -> cache_write+tag_write in LOOKUP, mem_we=1 with wdata 0x12345678, resp_valid at cycle 3.
//  4. cpu_req_valid held high during a miss:
//     -> ready=0 until IDLE; exactly one access per handshake; mem_addr stable while mem_req=1.
//  5. rst_n low while in MEM_RD:
//     -> mem_req=0 without a clock edge; resp_valid never pulses; ready=1 after release.
//  6. CACHE_PERF_CNT_EN, run tests 1-3:
//     -> hit_count=1, miss_count=2; undefined build compiles without the counter ports.

Source files
------------

// File: rtl/cache_access_sequencer_if.sv
// CPU request/response, cache array and main-memory signals of the access sequencer.
// master = the sequencer, slave = the CPU/cache/memory environment around it.
interface cache_access_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshakes: a CPU request transfers on the cycle where cpu_req_valid & cpu_req_ready
  // are both high; cpu_resp_valid is a single-cycle completion pulse with no back-pressure;
  // mem_req and its qualifiers hold steady until the cycle mem_ack is seen high.
  logic              cpu_req_valid;
  logic              cpu_req_we;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [DATA_W-1:0] cpu_req_wdata;
  logic              cpu_req_ready;
  logic              cpu_resp_valid;
  logic [DATA_W-1:0] cpu_resp_rdata;

  logic              hit;
  logic [DATA_W-1:0] cache_rdata;
  logic              cache_read;
  logic              cache_write;
  logic              tag_write;
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_wdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    input  hit, cache_rdata,
    output cache_read, cache_write, tag_write, cache_addr, cache_wdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    output hit, cache_rdata,
    input  cache_read, cache_write, tag_write, cache_addr, cache_wdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cache_access_sequencer.sv
// Sequences one CPU access at a time through a direct-mapped, write-allocate, write-through cache.
// Optional hit/miss performance counters are enabled by defining CACHE_PERF_CNT_EN.
module cache_access_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef CACHE_PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cache_access_sequencer_if.master      bus,
  output logic [2:0]                    o_dbg_state
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]              hit_count,
  output logic [CNT_W-1:0]              miss_count
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_MEM_RD = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_MEM_WR = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              w_accept;

  assign w_accept = (r_state == S_IDLE) && bus.cpu_req_valid;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (bus.cpu_req_valid) w_next_state = S_LOOKUP;
      S_LOOKUP: begin
        if (r_we)         w_next_state = S_MEM_WR;
        else if (bus.hit) w_next_state = S_RESP;
        else              w_next_state = S_MEM_RD;
      end
      S_MEM_RD: if (bus.mem_ack) w_next_state = S_FILL;
      S_FILL:   w_next_state = S_RESP;
      S_MEM_WR: if (bus.mem_ack) w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request fields are frozen at acceptance; later CPU bus activity cannot disturb the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_addr  <= bus.cpu_req_addr;
      r_we    <= bus.cpu_req_we;
      r_wdata <= bus.cpu_req_wdata;
    end
  end

  // r_rdata is cleared on accept so a write completes with zero response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_accept) begin
      r_rdata <= '0;
    end else if ((r_state == S_LOOKUP) && !r_we && bus.hit) begin
      r_rdata <= bus.cache_rdata;
    end else if ((r_state == S_MEM_RD) && bus.mem_ack) begin
      r_rdata <= bus.mem_rdata;
    end
  end

  always_comb begin
    bus.cpu_req_ready  = 1'b0;
    bus.cpu_resp_valid = 1'b0;
    bus.cache_read     = 1'b0;
    bus.cache_write    = 1'b0;
    bus.tag_write      = 1'b0;
    bus.mem_req        = 1'b0;
    bus.mem_we         = 1'b0;
    case (r_state)
      S_IDLE:   bus.cpu_req_ready = 1'b1;
      S_LOOKUP: begin
        bus.cache_read  = !r_we;
        bus.cache_write = r_we;
        bus.tag_write   = r_we;
      end
      S_MEM_RD: bus.mem_req = 1'b1;
      S_FILL: begin
        bus.cache_write = 1'b1;
        bus.tag_write   = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
      end
      S_RESP:   bus.cpu_resp_valid = 1'b1;
      default:  bus.cpu_req_ready = 1'b0;
    endcase
  end

  assign bus.cache_addr     = r_addr;
  assign bus.mem_addr       = r_addr;
  assign bus.mem_wdata      = r_wdata;
  assign bus.cache_wdata    = (r_state == S_FILL) ? r_rdata : r_wdata;
  assign bus.cpu_resp_rdata = (r_state == S_RESP) ? r_rdata : '0;
  assign o_dbg_state        = r_state;

`ifdef CACHE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_miss_count;

  // Every LOOKUP cycle classifies exactly one access; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (bus.hit) begin
        if (r_hit_count != '1) r_hit_count <= r_hit_count + CNT_ONE;
      end else begin
        if (r_miss_count != '1) r_miss_count <= r_miss_count + CNT_ONE;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_access_sequencer.sv
// Bench for cache_access_sequencer: directed vector table, reset-in-flight sequence and
// randomized accesses checked against a transaction-level model of latency and side effects.
module tb_cache_access_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_access_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cache_access_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] crdata;
    int          n;
    logic [31:0] mrdata;
    logic        hold;
    int          exp_lat;
    logic [31:0] exp_rdata;
    int          exp_mreq;
    int          exp_cwr;
    logic [31:0] exp_cwdata;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  int          o_lat, o_mreq, o_cwr, o_twr;
  logic [31:0] o_rdata, o_cwdata;
  bit          o_cread, o_proto, o_pulse;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Expected outcome of one access, straight from the access rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (!v.we && v.hit) begin
      r.exp_lat = 2; r.exp_rdata = v.crdata; r.exp_mreq = 0; r.exp_cwr = 0; r.exp_cwdata = '0;
    end else if (!v.we) begin
      r.exp_lat = 3 + v.n; r.exp_rdata = v.mrdata; r.exp_mreq = v.n; r.exp_cwr = 1;
      r.exp_cwdata = v.mrdata;
    end else begin
      r.exp_lat = 2 + v.n; r.exp_rdata = '0; r.exp_mreq = v.n; r.exp_cwr = 1;
      r.exp_cwdata = v.wdata;
    end
    return r;
  endfunction

  task automatic drive_idle_inputs();
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_we    = 1'b0;
    bus.cpu_req_addr  = '0;
    bus.cpu_req_wdata = '0;
    bus.hit           = 1'b0;
    bus.cache_rdata   = '0;
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  // Drives one access and records what the DUT did, cycle by cycle, until its response.
  task automatic run_txn(input vec_t v, input bit spur);
    int  k = 0;
    bit  done = 0;
    o_lat = -1; o_mreq = 0; o_cwr = 0; o_twr = 0; o_rdata = '0; o_cwdata = '0;
    o_cread = 0; o_proto = 1; o_pulse = 0;
    @(negedge clk);
    chk("idle_ready", bus.cpu_req_ready, 1);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we    = v.we;
    bus.cpu_req_addr  = v.addr;
    bus.cpu_req_wdata = v.wdata;
    bus.hit           = v.hit;
    bus.cache_rdata   = v.crdata;
    bus.mem_ack       = 1'b0;
    for (int c = 1; c <= 300 && !done; c++) begin
      @(negedge clk);
      if (!v.hold) bus.cpu_req_valid = 1'b0;
      bus.cpu_req_addr  = $urandom;
      bus.cpu_req_wdata = $urandom;
      bus.cpu_req_we    = 1'($urandom_range(0, 1));
      if (bus.cpu_req_ready) o_proto = 0;
      if (bus.cache_read && (bus.cache_write || bus.tag_write)) o_proto = 0;
      if ((bus.cache_read || bus.cache_write || bus.tag_write) && bus.cache_addr !== v.addr)
        o_proto = 0;
      if (bus.cache_read) o_cread = 1;
      if (bus.cache_write) begin o_cwr++; o_cwdata = bus.cache_wdata; end
      if (bus.tag_write) o_twr++;
      if (bus.mem_req) begin
        o_mreq++;
        if (bus.mem_addr !== v.addr || bus.mem_we !== v.we || (v.we && bus.mem_wdata !== v.wdata))
          o_proto = 0;
        k++;
        bus.mem_ack   = (k == v.n);
        bus.mem_rdata = (k == v.n) ? v.mrdata : $urandom;
      end else begin
        bus.mem_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mem_rdata = $urandom;
      end
      if (bus.cpu_resp_valid) begin
        o_lat = c; o_rdata = bus.cpu_resp_rdata; done = 1;
      end
    end
    if (done) begin
      @(negedge clk);
      bus.cpu_req_valid = 1'b0;
      bus.mem_ack       = 1'b0;
      o_pulse = bus.cpu_req_ready && !bus.cpu_resp_valid;
    end
  endtask

  task automatic apply_and_check(input vec_t v, input bit spur, input string tag);
    run_txn(v, spur);
    if (v.hit) exp_hits++; else exp_misses++;
    chk({tag, "_latency"}, 64'(o_lat), 64'(v.exp_lat));
    chk({tag, "_rdata"}, o_rdata, v.exp_rdata);
    chk({tag, "_mem_req_cycles"}, 64'(o_mreq), 64'(v.exp_mreq));
    chk({tag, "_cache_write_cycles"}, 64'(o_cwr), 64'(v.exp_cwr));
    chk({tag, "_tag_write_cycles"}, 64'(o_twr), 64'(v.exp_cwr));
    if (v.exp_cwr > 0) chk({tag, "_cache_wdata"}, o_cwdata, v.exp_cwdata);
    if (!v.we && v.hit) chk({tag, "_cache_read"}, o_cread, 1);
    else if (v.we) chk({tag, "_cache_read"}, o_cread, 0);
    chk({tag, "_protocol"}, o_proto, 1);
    chk({tag, "_resp_pulse"}, o_pulse, 1);
`ifdef CACHE_PERF_CNT_EN
    chk({tag, "_hit_count"}, hit_count, 64'(exp_hits));
    chk({tag, "_miss_count"}, miss_count, 64'(exp_misses));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    vec_t v;
    bit   saw_resp;

    drive_idle_inputs();
    tbl[0] = '{we:0, addr:32'h100, wdata:0, hit:0, crdata:32'h0BAD0BAD, n:3, mrdata:32'hDEADBEEF,
               hold:0, exp_lat:6, exp_rdata:32'hDEADBEEF, exp_mreq:3, exp_cwr:1,
               exp_cwdata:32'hDEADBEEF};
    tbl[1] = '{we:0, addr:32'h100, wdata:0, hit:1, crdata:32'hDEADBEEF, n:1, mrdata:32'h11111111,
               hold:0, exp_lat:2, exp_rdata:32'hDEADBEEF, exp_mreq:0, exp_cwr:0, exp_cwdata:0};
    tbl[2] = '{we:1, addr:32'h200, wdata:32'h12345678, hit:0, crdata:0, n:1, mrdata:32'h22222222,
               hold:0, exp_lat:3, exp_rdata:0, exp_mreq:1, exp_cwr:1, exp_cwdata:32'h12345678};
    tbl[3] = '{we:0, addr:32'h400, wdata:32'h5A5A5A5A, hit:0, crdata:0, n:2, mrdata:32'hCAFEF00D,
               hold:1, exp_lat:5, exp_rdata:32'hCAFEF00D, exp_mreq:2, exp_cwr:1,
               exp_cwdata:32'hCAFEF00D};

    @(negedge clk);
    chk("rst_ready", bus.cpu_req_ready, 1);
    chk("rst_resp_valid", bus.cpu_resp_valid, 0);
    chk("rst_resp_rdata", bus.cpu_resp_rdata, 0);
    chk("rst_strobes", {bus.cache_read, bus.cache_write, bus.tag_write}, 0);
    chk("rst_mem_req", {bus.mem_req, bus.mem_we}, 0);
    chk("rst_addr", {bus.mem_addr, bus.cache_addr}, 0);
    chk("rst_wdata", {bus.mem_wdata, bus.cache_wdata}, 0);
`ifdef CACHE_PERF_CNT_EN
    chk("rst_counters", {hit_count, miss_count}, 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      apply_and_check(tbl[i], 1'b0, $sformatf("vec%0d", i));
`ifdef CACHE_PERF_CNT_EN
      if (i == 2) begin
        chk("perf_after_three_hit", hit_count, 1);
        chk("perf_after_three_miss", miss_count, 2);
      end
`endif
    end

    // Reset while the read miss waits on memory.
    @(negedge clk);
    bus.cpu_req_valid = 1'b1; bus.cpu_req_we = 1'b0; bus.cpu_req_addr = 32'h300;
    bus.hit = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_req_before", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req_async", bus.mem_req, 0);
    chk("rst_mid_ready_async", bus.cpu_req_ready, 1);
    saw_resp = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.cpu_resp_valid || bus.mem_req) saw_resp = 1;
    end
    rst_n = 1'b1;
    exp_hits = 0; exp_misses = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.cpu_resp_valid) saw_resp = 1;
    end
    chk("rst_mid_no_resp", saw_resp, 0);
    chk("rst_mid_ready_after", bus.cpu_req_ready, 1);

    for (int i = 0; i < 40; i++) begin
      v.we     = 1'($urandom_range(0, 1));
      v.addr   = $urandom;
      v.wdata  = $urandom;
      v.hit    = 1'($urandom_range(0, 1));
      v.crdata = $urandom;
      v.n      = $urandom_range(1, 6);
      v.mrdata = $urandom;
      v.hold   = ($urandom_range(0, 3) == 0);
      v = model(v);
      apply_and_check(v, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
